perf_counter_unit: RTL
======================

// Module: perf_counter_unit
// PURPOSE
//  Parametrised performance-monitor block: NUM_CTR programmable counters, each bound to one event class decoded
//  from the issued instruction (type/opcode). Adds a run/frozen FSM, a per-counter overflow policy, and an atomic
//  snapshot with registered readout. Sits beside the decode stage; software/testbench reads results via rd_* port.
// PARAMETERS
//  WIDTH     32  counter width in bits
//  NUM_CTR   8   number of programmable counters (>=1)
//  SATURATE  0   0: counters wrap to 0 past max; 1: counters hold at 2^WIDTH-1
//  IDX_W     $clog2(NUM_CTR) (min 1)  width of counter index buses
// PORTS
//  clk               in   1        clock, all state updates on posedge
//  rst               in   1        reset, asynchronous, active-high
//  instr_valid       in   1        instruction_type/opcode valid this cycle
//  instruction_type  in   2        00 mem, 01 scalar data, 10 control, 11 vector
//  opcode            in   5        instruction opcode
//  finish            in   1        program finished; freezes counting
//  clear             in   1        zero all counters/ovf flags, return to RUN
//  cfg_we            in   1        write event select of counter cfg_idx
//  cfg_idx           in   IDX_W    counter to configure
//  cfg_evt           in   3        event code (see BEHAVIOUR)
//  snap              in   1        copy all live counters into shadow set
//  rd_req            in   1        read shadow counter rd_idx
//  rd_idx            in   IDX_W    counter to read
//  rd_data           out  WIDTH    shadow value of rd_idx
//  rd_ovf            out  1        sticky overflow flag of rd_idx (shadowed)
//  rd_valid          out  1        rd_data/rd_ovf valid
//  frozen            out  1        FSM is in FROZEN
// BEHAVIOUR
//  Reset: counters, shadows, ovf flags, rd_data, rd_ovf, rd_valid, frozen = 0; FSM=RUN; event select of ctr i = i mod 8.
//  Decode stage: instr_valid/type/opcode registered once; events fire from registered copy (1-cycle latency).
//  Event codes: 0 none; 1 cycle (every RUN cycle, independent of instr_valid); 2 retired = valid and type!=10;
//   3 arith = (type 01, op[4]=0, op<=4) or (type 01, op[4]=1) or type 11;
//   4 stall = type 01, op[4]=0, op in 5..7; 5 memory = type 00; 6 vector = type 11; 7 immediate = type 01/11 with op[4]=1.
//   Events 3-7 require registered valid. Opcodes 8..15 with type 01 count only as retired.
//  FSM: RUN --finish--> FROZEN; FROZEN --clear--> RUN. In FROZEN no counter changes (cfg/snap/read still work).
//   finish held high in RUN after clear re-enters FROZEN next cycle. frozen=1 iff state FROZEN.
//  Increment: counter +1 when its event fires in RUN. At 2^WIDTH-1: SATURATE=0 wraps to 0, SATURATE=1 holds;
//   either way ovf flag sets (sticky until clear/cfg_we/rst).
//  cfg_we: sets select of cfg_idx and zeroes that counter and its ovf the same edge (no increment that cycle).
//   cfg_idx >= NUM_CTR ignored.
//  Priority per edge: rst > clear > cfg_we > increment. clear also zeroes decode register (pending event dropped),
//   shadows untouched.
//  snap: shadow[i] <= value counter i holds after this edge (includes the increment of this cycle); all at once.
//   snap concurrent with clear captures 0.
//  Read: rd_req at edge N -> rd_data/rd_ovf/rd_valid at N+1 for one cycle; back-to-back reads every cycle.
//   rd_idx >= NUM_CTR returns data 0, ovf 0, rd_valid 1. rd_req concurrent with snap returns pre-snap shadow.
// TESTING
//  1 Reset defaults: ctr0=none,1=cycle; run 10 idle cycles, snap, read idx1 -> rd_data=10 (+/-0 per latency rules), idx0 -> 0.
//  2 Mix: feed add(01,00000), sub imm(01,10001), load(00,x), vadd(11,00000), stall(01,00101), ctrl(10,x);
//    snap/read -> retired=5, arith=3, stall=1, memory=1, vector=1, immediate=1.
//  3 finish after 4 retired instrs then 3 more -> retired=4, frozen=1; clear -> counters 0, frozen=0.
//  4 WIDTH=4: 17 cycle events -> SATURATE=0 reads 1, ovf=1; SATURATE=1 reads 15, ovf=1.
//  5 cfg_we on ctr2 (evt 5) same cycle as a memory instr event and clear -> ctr2=0, select unchanged by clear rules.
//  6 rst asserted mid-run with rd_req pending -> rd_valid=0, all outputs 0 immediately (async).

Source files
------------

// File: rtl/perf_counter_unit.sv
// Performance-monitor block: NUM_CTR event counters fed from a registered decode copy,
// with a run/frozen FSM, wrap or saturate overflow policy, atomic snapshot and registered readout.
module perf_counter_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_CTR  = 8,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned IDX_W    = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [1:0]       instruction_type,
  input  logic [4:0]       opcode,
  input  logic             finish,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [2:0]       cfg_evt,
  input  logic             snap,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_ovf,
  output logic             rd_valid,
  output logic             frozen
);

  localparam int unsigned EVT_W = 3;

  typedef enum logic {ST_RUN, ST_FROZEN} state_t;

  state_t state_q, state_d;

  logic             dec_valid;
  logic [1:0]       dec_type;
  logic [4:0]       dec_op;

  logic [WIDTH-1:0] ctr_q  [NUM_CTR];
  logic [WIDTH-1:0] ctr_d  [NUM_CTR];
  logic [EVT_W-1:0] sel_q  [NUM_CTR];
  logic [EVT_W-1:0] sel_d  [NUM_CTR];
  logic [WIDTH-1:0] shd_q  [NUM_CTR];
  logic [NUM_CTR-1:0] ovf_q, ovf_d, shov_q;

  logic [7:0]       ev_c;
  logic             cfg_ok_c;
  logic [WIDTH-1:0] rd_sel_data_c;
  logic             rd_sel_ovf_c;

  // Decode-stage copy of the issued instruction; clear drops anything pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid <= 1'b0;
      dec_type  <= '0;
      dec_op    <= '0;
    end else if (clear) begin
      dec_valid <= 1'b0;
      dec_type  <= '0;
      dec_op    <= '0;
    end else begin
      dec_valid <= instr_valid;
      dec_type  <= instruction_type;
      dec_op    <= opcode;
    end
  end

  // Event classes, indexed by event code
  always_comb begin
    ev_c    = '0;
    ev_c[1] = 1'b1;
    ev_c[2] = dec_valid && (dec_type != 2'b10);
    ev_c[3] = dec_valid && (((dec_type == 2'b01) && !dec_op[4] && (dec_op <= 5'd4)) ||
                            ((dec_type == 2'b01) && dec_op[4]) ||
                            (dec_type == 2'b11));
    ev_c[4] = dec_valid && (dec_type == 2'b01) && !dec_op[4] &&
              (dec_op >= 5'd5) && (dec_op <= 5'd7);
    ev_c[5] = dec_valid && (dec_type == 2'b00);
    ev_c[6] = dec_valid && (dec_type == 2'b11);
    ev_c[7] = dec_valid && dec_op[4] && ((dec_type == 2'b01) || (dec_type == 2'b11));
  end

  assign cfg_ok_c = cfg_we && (32'(cfg_idx) < NUM_CTR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state plus next counter/flag/select values; clear beats cfg_we beats increment
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    sel_d   = sel_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ST_RUN;
      ovf_d   = '0;
      for (int unsigned i = 0; i < NUM_CTR; i++) begin
        ctr_d[i] = '0;
        if (cfg_ok_c && (cfg_idx == IDX_W'(i))) sel_d[i] = cfg_evt;
      end
    end else begin
      if ((state_q == ST_RUN) && finish) state_d = ST_FROZEN;
      for (int unsigned i = 0; i < NUM_CTR; i++) begin
        if (cfg_ok_c && (cfg_idx == IDX_W'(i))) begin
          sel_d[i] = cfg_evt;
          ctr_d[i] = '0;
          ovf_d[i] = 1'b0;
        end else if ((state_q == ST_RUN) && ev_c[sel_q[i]]) begin
          if (ctr_q[i] == {WIDTH{1'b1}}) begin
            ovf_d[i] = 1'b1;
            ctr_d[i] = SATURATE ? ctr_q[i] : '0;
          end else begin
            ctr_d[i] = ctr_q[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= '0;
      shov_q <= '0;
      for (int unsigned i = 0; i < NUM_CTR; i++) begin
        ctr_q[i] <= '0;
        shd_q[i] <= '0;
        sel_q[i] <= EVT_W'(i);
      end
    end else begin
      ctr_q <= ctr_d;
      sel_q <= sel_d;
      ovf_q <= ovf_d;
      if (snap) begin
        shd_q  <= ctr_d;
        shov_q <= ovf_d;
      end
    end
  end

  // Shadow read mux; out-of-range indices read as zero
  always_comb begin
    rd_sel_data_c = '0;
    rd_sel_ovf_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_CTR; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_sel_data_c = shd_q[i];
        rd_sel_ovf_c  = shov_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= rd_sel_data_c;
        rd_ovf  <= rd_sel_ovf_c;
      end
    end
  end

  assign frozen = (state_q == ST_FROZEN);

endmodule
